// File: rtl/add8_eval_pkg.sv
// Shared types, default widths and the |x - y| helper for the approximate-adder
// error monitor.
package add8_eval_pkg;

  localparam int W_DEF     = 8;
  localparam int CNT_W_DEF = 16;
  localparam int ACC_W_DEF = CNT_W_DEF + W_DEF + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Magnitude of the difference of two W+1-bit sums, taken in W+2-bit signed math.
  function automatic logic [W_DEF:0] abs_diff(input logic [W_DEF:0] x,
                                               input logic [W_DEF:0] y);
    logic signed [W_DEF+1:0] d;
    logic        [W_DEF+1:0] m;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    m = d[W_DEF+1] ? -d : d;
    return m[W_DEF:0];
  endfunction

endpackage

// File: rtl/add8_err_stage.sv
// Two-stage datapath: S1 captures the triple and the exact sum, S2 registers
// the absolute error together with the operands that produced it.
module add8_err_stage
  import add8_eval_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_fire,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W:0]   i_o,
  output logic         o_valid,
  output logic [W:0]   o_err,
  output logic [W-1:0] o_a,
  output logic [W-1:0] o_b
);

  logic         r_v1, r_v2;
  logic [W-1:0] r_a1, r_b1, r_a2, r_b2;
  logic [W:0]   r_o1, r_exact1, r_err2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= i_fire;
      r_v2 <= r_v1;
    end
  end

  // NOTE: payload registers carry no reset; the valid bits alone decide whether
  // their contents are ever consumed, so resetting them would only add fan-out.
  always_ff @(posedge clk) begin
    if (i_fire) begin
      r_a1     <= i_a;
      r_b1     <= i_b;
      r_o1     <= i_o;
      r_exact1 <= {1'b0, i_a} + {1'b0, i_b};
    end
    if (r_v1) begin
      r_err2 <= abs_diff(r_o1, r_exact1);
      r_a2   <= r_a1;
      r_b2   <= r_b1;
    end
  end

  assign o_valid = r_v2;
  assign o_err   = r_err2;
  assign o_a     = r_a2;
  assign o_b     = r_b2;

endmodule

// File: rtl/add8_err_monitor.sv
// Run controller and accumulators characterising an approximate 8-bit adder:
// total |error| (saturating), worst-case error with its operands, error count.
module add8_err_monitor
  import add8_eval_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_o,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [W:0]       wce,
  output logic [W-1:0]     wce_a,
  output logic [W-1:0]     wce_b,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] sample_cnt
);

  state_e           r_state, w_state_nxt;
  logic             r_drain_cnt;
  logic [CNT_W-1:0] r_len, r_err_cnt, r_sample_cnt;
  logic [ACC_W-1:0] r_sum;
  logic [W:0]       r_wce;
  logic [W-1:0]     r_wce_a, r_wce_b;

  logic             w_fire, w_last, w_start;
  logic             w_err_valid;
  logic [W:0]       w_err;
  logic [W-1:0]     w_err_a, w_err_b;
  logic [ACC_W:0]   w_sum_ext;

  assign w_start = start && (r_state == IDLE || r_state == DONE);
  assign w_fire  = in_valid && (r_state == RUN);
  assign w_last  = w_fire && (r_sample_cnt + CNT_W'(1) == r_len);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_drain_cnt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= (r_state == DRAIN) ? ~r_drain_cnt : 1'b0;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (w_start) w_state_nxt = (len != '0) ? RUN : DRAIN;
      RUN:        if (w_last) w_state_nxt = DRAIN;
      DRAIN:      if (r_drain_cnt) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  add8_err_stage #(.W(W)) u_stage (
    .clk     (clk),
    .rst     (rst),
    .i_fire  (w_fire),
    .i_a     (in_a),
    .i_b     (in_b),
    .i_o     (in_o),
    .o_valid (w_err_valid),
    .o_err   (w_err),
    .o_a     (w_err_a),
    .o_b     (w_err_b)
  );

  // One extra carry bit detects overflow so the total clamps instead of wrapping.
  assign w_sum_ext = (ACC_W+1)'(r_sum) + (ACC_W+1)'(w_err);

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_len        <= rst ? '0 : len;
      r_sum        <= '0;
      r_wce        <= '0;
      r_wce_a      <= '0;
      r_wce_b      <= '0;
      r_err_cnt    <= '0;
      r_sample_cnt <= '0;
    end else begin
      if (w_fire) r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      if (w_err_valid) begin
        r_sum <= w_sum_ext[ACC_W] ? '1 : w_sum_ext[ACC_W-1:0];
        if (w_err > r_wce) begin
          r_wce   <= w_err;
          r_wce_a <= w_err_a;
          r_wce_b <= w_err_b;
        end
        if (w_err != '0) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready    = (r_state == RUN);
  assign busy        = (r_state == RUN) || (r_state == DRAIN);
  assign done        = (r_state == DONE);
  assign sum_abs_err = r_sum;
  assign wce         = r_wce;
  assign wce_a       = r_wce_a;
  assign wce_b       = r_wce_b;
  assign err_cnt     = r_err_cnt;
  assign sample_cnt  = r_sample_cnt;

endmodule

// File: tb/tb_add8_err_monitor.sv
// Scoreboard bench: stimulus pushes the expected run summary, a monitor pops and
// compares when done rises. A second instance with a 10-bit accumulator shares
// the stimulus to exercise saturation.
module tb_add8_err_monitor;

  localparam int W     = 8;
  localparam int CNT_W = 16;
  localparam longint MAX26 = (64'd1 << 26) - 1;
  localparam longint MAX10 = 1023;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in_a = '0, in_b = '0;
  logic [W:0]       in_o = '0;

  logic             in_ready, busy, done;
  logic [25:0]      sum_abs_err;
  logic [W:0]       wce;
  logic [W-1:0]     wce_a, wce_b;
  logic [CNT_W-1:0] err_cnt, sample_cnt;

  logic             s_in_ready, s_busy, s_done;
  logic [9:0]       s_sum;
  logic [W:0]       s_wce;
  logic [W-1:0]     s_wce_a, s_wce_b;
  logic [CNT_W-1:0] s_err_cnt, s_sample_cnt;

  add8_err_monitor dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(busy), .done(done), .sum_abs_err(sum_abs_err),
    .wce(wce), .wce_a(wce_a), .wce_b(wce_b),
    .err_cnt(err_cnt), .sample_cnt(sample_cnt)
  );

  add8_err_monitor #(.ACC_W(10)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(s_busy), .done(s_done), .sum_abs_err(s_sum),
    .wce(s_wce), .wce_a(s_wce_a), .wce_b(s_wce_b),
    .err_cnt(s_err_cnt), .sample_cnt(s_sample_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    longint sum;
    int     wce, wa, wb, errc, samp, done_cyc;
  } exp_t;

  typedef struct {
    int a, b, o;
  } trip_t;

  exp_t  exp_q[$];
  trip_t trip_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint m);
    return (v > m) ? m : v;
  endfunction

  // Monitor: one expected summary per rising edge of done.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no run pending", cyc);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle",      cyc,          e.done_cyc);
        check("sum_abs_err",     sum_abs_err,  sat(e.sum, MAX26));
        check("wce",             wce,          e.wce);
        check("wce_a",           wce_a,        e.wa);
        check("wce_b",           wce_b,        e.wb);
        check("err_cnt",         err_cnt,      e.errc);
        check("sample_cnt",      sample_cnt,   e.samp);
        check("sat_done",        s_done,       1);
        check("sat_sum_abs_err", s_sum,        sat(e.sum, MAX10));
        check("sat_wce",         s_wce,        e.wce);
        check("sat_err_cnt",     s_err_cnt,    e.errc);
        check("sat_sample_cnt",  s_sample_cnt, e.samp);
      end
    end
    done_prev = done;
  end

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"},    in_ready,     0);
    check({tag, "_busy"},        busy,         0);
    check({tag, "_done"},        done,         0);
    check({tag, "_sum_abs_err"}, sum_abs_err,  0);
    check({tag, "_wce"},         wce,          0);
    check({tag, "_wce_ab"},      {wce_a, wce_b}, 0);
    check({tag, "_err_cnt"},     err_cnt,      0);
    check({tag, "_sample_cnt"},  sample_cnt,   0);
    check({tag, "_sat_sum"},     s_sum,        0);
    check({tag, "_sat_done"},    s_done,       0);
  endtask

  task automatic drive_triple(input trip_t t);
    in_a = W'(t.a);
    in_b = W'(t.b);
    in_o = (W+1)'(t.o);
  endtask

  function automatic trip_t rand_triple();
    trip_t t;
    t.a = int'($urandom_range(0, 255));
    t.b = int'($urandom_range(0, 255));
    t.o = ($urandom_range(0, 1) == 1) ? t.a + t.b : int'($urandom_range(0, 511));
    return t;
  endfunction

  // vmode: 0 continuous valid, 1 fixed 1-0-0-1-1-0-1-1 pattern, 2 random.
  task automatic run(input int n, input int vmode, input bit rnd_data,
                     input bit start_mid, input bit extra_valid);
    exp_t       e;
    trip_t      t;
    int         acc, last, s, i, err;
    bit         v;
    logic [7:0] pat;
    pat = 8'b1101_1001;
    e   = '{default: 0};
    acc = 0;
    i   = 0;
    @(posedge clk); #1;
    start = 1'b1;
    len   = CNT_W'(n);
    s     = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    last = s;
    while (acc < n) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? pat[i % 8] : 1'($urandom_range(0, 1));
      start = start_mid && (i == 1);
      if (start) len = CNT_W'(1);
      in_valid = v;
      if (v) begin
        t = rnd_data ? rand_triple() : trip_q.pop_front();
        drive_triple(t);
        err = t.o - (t.a + t.b);
        if (err < 0) err = -err;
        e.sum += err;
        if (err > e.wce) begin
          e.wce = err;
          e.wa  = t.a;
          e.wb  = t.b;
        end
        if (err != 0) e.errc++;
        acc++;
        last = cyc;
      end else begin
        drive_triple(rand_triple());
      end
      i++;
      @(posedge clk); #1;
    end
    start      = 1'b0;
    e.samp     = n;
    e.done_cyc = (n == 0) ? s + 3 : last + 3;
    exp_q.push_back(e);
    if (n > 0) check("in_ready_after_last", in_ready, 0);
    if (extra_valid) begin
      repeat (2) begin
        in_valid = 1'b1;
        drive_triple(rand_triple());
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL done_timeout: got no done within bound expected done at cycle %0d", e.done_cyc);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("por");

    // Exact adder: every error zero.
    trip_q = '{'{0, 0, 0}, '{255, 255, 510}, '{17, 3, 20}, '{128, 128, 256}};
    run(4, 0, 0, 0, 0);

    // Mixed errors 4, 16, 16: the tie keeps the first operands.
    trip_q = '{'{4, 1, 1}, '{10, 10, 36}, '{7, 9, 0}};
    run(3, 0, 0, 0, 0);

    // Gapped valid with extra valid beats after the last transfer.
    run(5, 1, 1, 0, 1);

    // Empty run.
    run(0, 0, 1, 0, 0);

    // A start pulse during RUN must be ignored.
    run(6, 0, 1, 1, 0);

    // Saturation of the 10-bit accumulator: 5 x 510.
    repeat (5) trip_q.push_back('{255, 255, 0});
    run(5, 0, 0, 0, 0);

    // Reset after 2 of 6 samples, then a clean run.
    @(posedge clk); #1;
    start = 1'b1;
    len   = CNT_W'(6);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      in_valid = 1'b1;
      drive_triple('{200, 100, 0});
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("mid_reset");
    rst      = 1'b0;
    in_valid = 1'b0;
    trip_q   = '{'{1, 1, 3}};
    run(1, 0, 0, 0, 0);

    // Randomized runs.
    for (int k = 0; k < 6; k++) run(int'($urandom_range(1, 20)), 2, 1, 0, k[0]);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/add8_err_monitor.md
# add8_err_monitor

Sequential error-characterisation stage placed directly downstream of an 8-bit approximate adder instance. It takes each operand pair together with the approximate 9-bit sum that adder produced, recomputes the exact sum, and accumulates four figures over a programmed run of samples: total absolute error, worst-case error (with the operands that caused it), count of erroneous samples, and samples seen. The run results feed the library's MAE/WCE/EP characterisation flow on FPGA or emulation.

## Interface
Parameters:
- W, 8, operand width; sums are W+1 bits
- CNT_W, 16, width of the run length and sample/error counters
- ACC_W, 26, width of the absolute-error accumulator (CNT_W+W+2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a run, sampled only in IDLE or DONE
- len  in  CNT_W  number of samples in the run, latched on start
- in_valid  in  1  operand/result triple valid
- in_ready  out  1  block accepts a triple this cycle
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_o  in  W+1  approximate sum from the adder under test
- busy  out  1  run in progress (RUN or DRAIN)
- done  out  1  results valid and held
- sum_abs_err  out  ACC_W  Σ|in_o − (in_a+in_b)|, saturating
- wce  out  W+1  maximum |error| in the run
- wce_a, wce_b  out  W  operands of the first sample reaching wce
- err_cnt  out  CNT_W  samples with nonzero error
- sample_cnt  out  CNT_W  samples accepted

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: latch len, clear all accumulators and counters, deassert done. Go to RUN if len≠0, else to DRAIN.
- RUN: in_ready=1. A transfer is in_valid && in_ready. On the transfer that makes sample_cnt equal to len, go to DRAIN in the next cycle; in_ready drops that cycle.
- DRAIN: lasts exactly 2 cycles, until the pipeline is empty. Then go to DONE.
- DONE: done=1; all result outputs hold until the next start or rst.
- start is ignored in RUN and DRAIN. in_valid is ignored outside RUN.
- Error: exact = in_a+in_b, W+1 bits with no overflow. err = |in_o − exact|, computed in W+2-bit signed arithmetic, result W+1 bits.
- sum_abs_err saturates at all-ones; it never wraps.
- wce updates only on strict err > wce, so ties keep the first operands.
- err_cnt increments when err≠0.
- Counters cannot overflow, since len ≤ 2^CNT_W−1.
- rst: state=IDLE; in_ready, busy, done and all results = 0; pipeline valid bits = 0. This applies mid-run as well; any partial run is discarded.

## Timing
- Pipeline has 2 stages:
  - S1 registers a, b, in_o and the exact sum.
  - S2 computes err and updates the accumulators.
- A transfer in cycle t is reflected in the result registers at the clk edge ending cycle t+2.
- sample_cnt counts at accept (cycle t). The other results update 2 cycles later.
- Throughput is one triple per cycle, with no bubbles required.
- A run of len samples with continuous valid: done rises len+3 cycles after the start cycle (1 cycle to enter RUN, len transfers, 2 DRAIN cycles).
- busy = (state==RUN || state==DRAIN). in_ready = (state==RUN). Both are registered-state decodes with no combinational path from in_valid.
- A start in DONE clears done in the next cycle.

## Structure
- Package add8_eval_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - default W, CNT_W and ACC_W
  - the function abs_diff(logic [W:0] x, y)
- One sub-module, add8_err_stage: the S1/S2 datapath (exact sum, |error|, valid pipe). add8_err_monitor keeps the FSM, counters and accumulators.

## Test plan
- Exact adder: len=4; triples (0,0,0), (255,255,510), (17,3,20), (128,128,256) → after done: sum_abs_err=0, wce=0, err_cnt=0, sample_cnt=4.
- Mixed errors: len=3; (4,1,o=1), (10,10,o=36), (7,9,o=0) → errors 4, 16, 16. Result: sum_abs_err=36, wce=16, wce_a=10, wce_b=10 (first tie kept), err_cnt=3.
- Backpressure/gaps: len=5, in_valid toggled 1-0-0-1-1-0-1-1 → exactly 5 accepted; in_ready=0 from the cycle after the 5th transfer; done 3 cycles after the last transfer.
- Timing and boundaries:
  - With continuous valid, done rises exactly len+3 cycles after start.
  - len=0 → done rises 3 cycles after start, with all results 0.
  - start asserted during RUN has no effect.
- Saturation: with ACC_W overridden to 10, a run with len=5 and every error 510 → sum_abs_err=1023, not wrapped.
- Reset mid-run: rst asserted after 2 of 6 samples → next cycle all outputs 0 and state IDLE. A subsequent start with len=1 and triple (1,1,3) gives sum_abs_err=1, err_cnt=1, and no residue from the aborted run.
